// File: rtl/gpio_pkg.sv
// gpio_pkg: register map offsets and bus helpers shared by the GPIO peripheral.
package gpio_pkg;
  localparam int GPIO_WIN = 32;
  localparam logic [4:0] OFF_OUT      = 5'h00;
  localparam logic [4:0] OFF_DIR      = 5'h04;
  localparam logic [4:0] OFF_IN       = 5'h08;
  localparam logic [4:0] OFF_IRQ_EN   = 5'h0C;
  localparam logic [4:0] OFF_IRQ_STAT = 5'h10;
  localparam logic [4:0] OFF_EDGE_SEL = 5'h14;
  localparam logic [4:0] OFF_OUT_SET  = 5'h18;
  localparam logic [4:0] OFF_OUT_CLR  = 5'h1C;
  function automatic logic [31:0] lane_mask(input logic [3:0] en);
    return {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
  endfunction
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: STAGES-deep, WIDTH-wide input synchroniser; q is the last stage.
module gpio_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES*WIDTH-1:0] chain;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else chain <= {chain[(STAGES-1)*WIDTH-1:0], d};
  end
  assign q = chain[STAGES*WIDTH-1 -: WIDTH];
endmodule

// File: rtl/gpio_periph.sv
// gpio_periph: memory-mapped GPIO with direction, set/clear access, synchronised
// inputs, per-pin rising/falling edge capture and a registered level interrupt.
module gpio_periph
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [31:0]      BASE_ADDR   = 32'h2000_0000,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wr,
  input  logic [3:0]       data_wr_en,
  output logic [31:0]      data_rd,
  output logic             sel,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  logic [WIDTH-1:0] out_r, dir_r, in_r, prev_r, en_r, stat_r, esel_r;
  logic [WIDTH-1:0] ev, wm, wd, rd_v;
  logic [31:0] lm;
  logic [4:0] off;
  logic we;
  logic unused_bits;
  // The window is 32-byte aligned, so decode reduces to matching the upper address bits.
  assign sel = data_addr[31:5] == BASE_ADDR[31:5];
  assign off = {data_addr[4:2], 2'b00};
  assign we = sel && |data_wr_en;
  assign lm = lane_mask(data_wr_en);
  assign wm = lm[WIDTH-1:0];
  assign wd = data_wr[WIDTH-1:0] & wm;
  assign unused_bits = ^{data_addr[1:0], data_wr, lm};
  gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (gpio_in),
    .q    (in_r)
  );
  assign ev = (esel_r & ~in_r & prev_r) | (~esel_r & in_r & ~prev_r);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r  <= OUT_RESET;
      dir_r  <= '0;
      en_r   <= '0;
      stat_r <= '0;
      esel_r <= '0;
      prev_r <= '0;
      irq    <= 1'b0;
    end else begin
      prev_r <= in_r;
      irq    <= |(stat_r & en_r);
      out_r  <= !we ? out_r :
                off == OFF_OUT     ? (out_r & ~wm) | wd :
                off == OFF_OUT_SET ? out_r | wd :
                off == OFF_OUT_CLR ? out_r & ~wd : out_r;
      dir_r  <= we && off == OFF_DIR      ? (dir_r & ~wm) | wd  : dir_r;
      en_r   <= we && off == OFF_IRQ_EN   ? (en_r & ~wm) | wd   : en_r;
      esel_r <= we && off == OFF_EDGE_SEL ? (esel_r & ~wm) | wd : esel_r;
      // New events are OR-ed after the W1C so a coincident event keeps its bit.
      stat_r <= (stat_r & ~(we && off == OFF_IRQ_STAT ? wd : '0)) | ev;
    end
  end
  always_comb begin
    rd_v = off == OFF_OUT      ? out_r  :
           off == OFF_DIR      ? dir_r  :
           off == OFF_IN       ? in_r   :
           off == OFF_IRQ_EN   ? en_r   :
           off == OFF_IRQ_STAT ? stat_r :
           off == OFF_EDGE_SEL ? esel_r : '0;
    data_rd = sel ? 32'(rd_v) : '0;
  end
  assign gpio_out = out_r;
  assign gpio_oe  = dir_r;
endmodule

// File: tb/tb_gpio_periph.sv
// tb_gpio_periph: directed and randomized checks of gpio_periph against a cycle-level behavioural model.
module tb_gpio_periph;
  localparam int W = 16;
  localparam int SS = 2;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [W-1:0] ORST = 16'h0005;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rd;
  logic [3:0] wen = '0;
  logic sel, irq;
  logic [W-1:0] pins = '0, gout, goe;
  int checks = 0, failures = 0;
  logic [W-1:0] m_out, m_dir, m_en, m_stat, m_esel;
  logic m_irq;
  logic [W-1:0] q[$];
  gpio_periph #(.WIDTH(W), .BASE_ADDR(BASE), .SYNC_STAGES(SS), .OUT_RESET(ORST)) dut (
    .clk(clk), .rst_n(rst_n), .data_addr(addr), .data_wr(wdata), .data_wr_en(wen),
    .data_rd(rd), .sel(sel), .gpio_in(pins), .gpio_out(gout), .gpio_oe(goe), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit in_win(input logic [31:0] a);
    return a >= BASE && a < BASE + 32;
  endfunction
  function automatic logic [31:0] m_read(input logic [31:0] a);
    int o;
    if (!in_win(a)) return 0;
    o = int'((a - BASE) / 4);
    case (o)
      0: return 32'(m_out);
      1: return 32'(m_dir);
      2: return 32'(q[1]);
      3: return 32'(m_en);
      4: return 32'(m_stat);
      5: return 32'(m_esel);
      default: return 0;
    endcase
  endfunction
  task automatic m_reset();
    m_out = ORST; m_dir = '0; m_en = '0; m_stat = '0; m_esel = '0; m_irq = 1'b0;
    q = {};
    for (int i = 0; i <= SS; i++) q.push_back('0);
  endtask
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] e, input logic [W-1:0] p);
    logic [W-1:0] in_v, pv, ev, mk, m, n_out, n_dir, n_en, n_esel, n_stat;
    logic [31:0] lm;
    logic n_irq;
    int o;
    addr = a; wdata = d; wen = e; pins = p;
    #1;
    check("sel", 32'(sel), 32'(in_win(a)));
    check("rd", rd, m_read(a));
    in_v = q[1]; pv = q[0];
    for (int i = 0; i < W; i++)
      ev[i] = m_esel[i] ? (pv[i] && !in_v[i]) : (in_v[i] && !pv[i]);
    for (int b = 0; b < 4; b++) lm[8*b +: 8] = e[b] ? 8'hFF : 8'h00;
    mk = lm[W-1:0];
    m = d[W-1:0] & mk;
    n_irq = (m_stat & m_en) != 0;
    n_out = m_out; n_dir = m_dir; n_en = m_en; n_esel = m_esel;
    n_stat = m_stat;
    if (in_win(a) && e != 0) begin
      o = int'((a - BASE) / 4);
      case (o)
        0: n_out = (m_out & ~mk) | m;
        1: n_dir = (m_dir & ~mk) | m;
        3: n_en = (m_en & ~mk) | m;
        4: n_stat = m_stat & ~m;
        5: n_esel = (m_esel & ~mk) | m;
        6: n_out = m_out | m;
        7: n_out = m_out & ~m;
        default: ;
      endcase
    end
    n_stat = n_stat | ev;
    @(posedge clk);
    #1;
    m_out = n_out; m_dir = n_dir; m_en = n_en; m_esel = n_esel; m_stat = n_stat; m_irq = n_irq;
    q.push_back(p);
    void'(q.pop_front());
    check("gpio_out", 32'(gout), 32'(m_out));
    check("gpio_oe", 32'(goe), 32'(m_dir));
    check("irq", 32'(irq), 32'(m_irq));
  endtask
  task automatic idle(input int n, input logic [W-1:0] p);
    for (int i = 0; i < n; i++) step(32'h0, 32'h0, 4'h0, p);
  endtask
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; wen = 4'h0;
    #1;
    check(tag, rd, exp);
  endtask
  logic [W-1:0] saved;
  logic [31:0] ra;
  initial begin
    m_reset();
    #12;
    @(negedge clk) rst_n = 1'b1;
    idle(2, '0);
    // byte lanes
    step(BASE, 32'h0, 4'hF, '0);
    step(BASE, 32'hABCD, 4'b0001, '0);
    check("lane0", 32'(gout), 32'h00CD);
    step(BASE, 32'hABCD, 4'b0010, '0);
    check("lane1", 32'(gout), 32'hABCD);
    // set / clear
    step(BASE, 32'h5, 4'hF, '0);
    step(BASE + 32'h18, 32'hA, 4'hF, '0);
    check("out_set", 32'(gout), 32'hF);
    step(BASE + 32'h1C, 32'h3, 4'hF, '0);
    check("out_clr", 32'(gout), 32'hC);
    peek("rd_set", BASE + 32'h18, 32'h0);
    peek("rd_clr", BASE + 32'h1C, 32'h0);
    // rising edge and irq latency
    step(BASE + 32'h0C, 32'h1, 4'hF, '0);
    idle(1, 16'h1);
    peek("in_lat1", BASE + 32'h08, 32'h0);
    idle(1, 16'h1);
    peek("in_lat2", BASE + 32'h08, 32'h1);
    peek("stat_lat2", BASE + 32'h10, 32'h0);
    idle(1, 16'h1);
    peek("stat_lat3", BASE + 32'h10, 32'h1);
    check("irq_lat3", 32'(irq), 32'h0);
    idle(1, 16'h1);
    check("irq_lat4", 32'(irq), 32'h1);
    step(BASE + 32'h10, 32'h1, 4'hF, 16'h1);
    check("irq_w1c0", 32'(irq), 32'h1);
    idle(1, 16'h1);
    check("irq_w1c1", 32'(irq), 32'h0);
    // falling mode and W1C/event collision
    step(BASE + 32'h14, 32'h2, 4'hF, 16'h1);
    idle(4, 16'h3);
    peek("fall_no_rise", BASE + 32'h10, 32'h0);
    idle(3, 16'h1);
    peek("fall_stat", BASE + 32'h10, 32'h2);
    step(BASE + 32'h10, 32'h2, 4'hF, 16'h1);
    idle(3, 16'h3);
    peek("fall_cleared", BASE + 32'h10, 32'h0);
    idle(2, 16'h1);
    step(BASE + 32'h10, 32'h2, 4'hF, 16'h1);
    peek("collision", BASE + 32'h10, 32'h2);
    // decode
    saved = gout;
    step(BASE + 32'h20, 32'hFFFF, 4'hF, 16'h1);
    step(BASE - 32'h4, 32'hFFFF, 4'hF, 16'h1);
    check("decode_out", 32'(gout), 32'(saved));
    peek("decode_oob_rd", BASE + 32'h20, 32'h0);
    peek("rd_unaligned_in", BASE + 32'h0B, 32'h1);
    // asynchronous reset mid-operation
    step(BASE, 32'hF, 4'hF, 16'h1);
    step(BASE + 32'h04, 32'hFF, 4'hF, 16'h1);
    check("pre_rst_out", 32'(gout), 32'hF);
    pins = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out", 32'(gout), 32'(ORST));
    check("rst_oe", 32'(goe), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    for (int o = 0; o < 8; o++) peek("rst_rd", BASE + 32'(4 * o), o == 0 ? 32'(ORST) : 32'h0);
    m_reset();
    @(negedge clk) rst_n = 1'b1;
    idle(1, '0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      ra = ($urandom % 8 == 0) ? (($urandom % 2 == 1) ? BASE + 32 + ($urandom % 64) : BASE - 1 - ($urandom % 64))
                               : BASE + ($urandom % 32);
      step(ra, $urandom, ($urandom % 3 == 0) ? 4'h0 : 4'($urandom), ($urandom % 4 == 0) ? W'($urandom) : pins);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
